// File: rtl/mm_ln_out_pack.sv
// mm_ln_out_pack: packs the D_W-bit mm_ln result stream into 32-bit AXI-stream words
// for the S2MM DMA channel.
//
// Lane order is little-endian: element k of a word sits in bits [k*D_W +: D_W].
// The block generates tlast itself after frame_len elements and sets tkeep on a short final word.
// Upstream in_tlast is only checked against frame_len. A mismatch sets the sticky err_len flag.
//
// Handshakes (both sides): a transfer happens on a rising clk edge when valid && ready.
// A producer never withdraws valid, and never changes its payload, until that transfer happens.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   frame_len           elements per frame, sampled on the first element of a frame (0 acts as 1)
//   in_tdata/tvalid/tready/tlast   element input from mm_ln
//   m_axis_tdata/tkeep/tlast/tvalid/tready   packed word output to the DMA
//   err_len             sticky upstream tlast/length mismatch flag
//   state_dbg           0 = IDLE (waiting for a frame's first element), 1 = RUN
//   word_cnt, frame_cnt saturating handshake / frame counters (only with PACK_STATS_EN)
//
// Build option: define PACK_STATS_EN to add word_cnt and frame_cnt.
module mm_ln_out_pack #(
    parameter int D_W          = 8,
    parameter int MATRIXSIZE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MATRIXSIZE_W-1:0] frame_len,
    input  logic [D_W-1:0]          in_tdata,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic                    in_tlast,
    output logic [31:0]             m_axis_tdata,
    output logic [3:0]              m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    err_len,
`ifdef PACK_STATS_EN
    output logic [31:0]             word_cnt,
    output logic [15:0]             frame_cnt,
`endif
    output logic                    state_dbg
);

    localparam int LANES  = 32 / D_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [LANE_W-1:0]       lane_cnt_q, lane_cnt_d;
    logic [MATRIXSIZE_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [MATRIXSIZE_W-1:0] flen_q, flen_d;
    logic [31:0]             acc_data_q, acc_data_d;
    logic [3:0]              acc_keep_q, acc_keep_d;
    logic                    acc_last_q, acc_last_d;
    logic                    acc_full_q, acc_full_d;
    logic [31:0]             obuf_data_q, obuf_data_d;
    logic [3:0]              obuf_keep_q, obuf_keep_d;
    logic                    obuf_last_q, obuf_last_d;
    logic                    obuf_valid_q, obuf_valid_d;
    logic                    err_q, err_d;
`ifdef PACK_STATS_EN
    logic [31:0]             word_cnt_q, word_cnt_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
`endif

    logic                    obuf_free;
    logic                    accept;
    logic [MATRIXSIZE_W-1:0] cur_flen;
    logic                    last_elem;
    logic                    close_word;
    logic [31:0]             word;
    logic [3:0]              keep;

    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        elem_cnt_d   = elem_cnt_q;
        flen_d       = flen_q;
        acc_data_d   = acc_data_q;
        acc_keep_d   = acc_keep_q;
        acc_last_d   = acc_last_q;
        acc_full_d   = acc_full_q;
        obuf_data_d  = obuf_data_q;
        obuf_keep_d  = obuf_keep_q;
        obuf_last_d  = obuf_last_q;
        obuf_valid_d = obuf_valid_q;
        err_d        = err_q;
`ifdef PACK_STATS_EN
        word_cnt_d   = word_cnt_q;
        frame_cnt_d  = frame_cnt_q;
`endif

        // obuf can take a new word this cycle if it is empty or is draining now.
        obuf_free = !obuf_valid_q || m_axis_tready;
        in_tready = !rst && (!acc_full_q || obuf_free);
        accept    = in_tvalid && in_tready;

        // While IDLE the incoming element starts a frame, so use the live frame_len.
        if (state_q == IDLE) begin
            cur_flen = (frame_len == '0) ? MATRIXSIZE_W'(1) : frame_len;
        end else begin
            cur_flen = flen_q;
        end
        last_elem  = (elem_cnt_q == cur_flen - MATRIXSIZE_W'(1));
        close_word = last_elem || (lane_cnt_q == LANE_W'(LANES - 1));

        // A completed acc only ever sits there while obuf is occupied, so lane_cnt is 0 here
        // and the new element starts from an empty word.
        word = acc_full_q ? 32'h0 : acc_data_q;
        word[lane_cnt_q * D_W +: D_W] = in_tdata;
        for (int b = 0; b < 4; b++) begin
            keep[b] = (b * 8) < ((int'(lane_cnt_q) + 1) * D_W);
        end

        if (obuf_valid_q && m_axis_tready) begin
            obuf_valid_d = 1'b0;
`ifdef PACK_STATS_EN
            if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 32'd1;
            if (obuf_last_q && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        end

        // Completed acc moves into obuf as soon as obuf frees up, even in its drain cycle.
        if (acc_full_q && obuf_free) begin
            obuf_data_d  = acc_data_q;
            obuf_keep_d  = acc_keep_q;
            obuf_last_d  = acc_last_q;
            obuf_valid_d = 1'b1;
            acc_full_d   = 1'b0;
            acc_data_d   = 32'h0;
        end

        if (accept) begin
            if (in_tlast != last_elem) err_d = 1'b1;

            if (close_word) begin
                lane_cnt_d = '0;
            end else begin
                lane_cnt_d = lane_cnt_q + LANE_W'(1);
            end

            if (last_elem) begin
                elem_cnt_d = '0;
                state_d    = IDLE;
            end else begin
                elem_cnt_d = elem_cnt_q + MATRIXSIZE_W'(1);
                state_d    = RUN;
            end
            if (state_q == IDLE) flen_d = cur_flen;

            // A closing word bypasses acc when obuf can take it, giving one-cycle latency.
            if (close_word && obuf_free && !acc_full_q) begin
                obuf_data_d  = word;
                obuf_keep_d  = keep;
                obuf_last_d  = last_elem;
                obuf_valid_d = 1'b1;
                acc_data_d   = 32'h0;
                acc_full_d   = 1'b0;
            end else begin
                acc_data_d   = word;
                acc_keep_d   = keep;
                acc_last_d   = last_elem;
                acc_full_d   = close_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lane_cnt_q   <= '0;
            elem_cnt_q   <= '0;
            flen_q       <= '0;
            acc_data_q   <= '0;
            acc_keep_q   <= '0;
            acc_last_q   <= 1'b0;
            acc_full_q   <= 1'b0;
            obuf_data_q  <= '0;
            obuf_keep_q  <= '0;
            obuf_last_q  <= 1'b0;
            obuf_valid_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef PACK_STATS_EN
            word_cnt_q   <= '0;
            frame_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lane_cnt_q   <= lane_cnt_d;
            elem_cnt_q   <= elem_cnt_d;
            flen_q       <= flen_d;
            acc_data_q   <= acc_data_d;
            acc_keep_q   <= acc_keep_d;
            acc_last_q   <= acc_last_d;
            acc_full_q   <= acc_full_d;
            obuf_data_q  <= obuf_data_d;
            obuf_keep_q  <= obuf_keep_d;
            obuf_last_q  <= obuf_last_d;
            obuf_valid_q <= obuf_valid_d;
            err_q        <= err_d;
`ifdef PACK_STATS_EN
            word_cnt_q   <= word_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    assign m_axis_tdata  = obuf_data_q;
    assign m_axis_tkeep  = obuf_keep_q;
    assign m_axis_tlast  = obuf_last_q;
    assign m_axis_tvalid = obuf_valid_q;
    assign err_len       = err_q;
    assign state_dbg     = (state_q == RUN);
`ifdef PACK_STATS_EN
    assign word_cnt      = word_cnt_q;
    assign frame_cnt     = frame_cnt_q;
`endif

endmodule

// File: tb/tb_mm_ln_out_pack.sv
// Bench for mm_ln_out_pack (D_W=8, 4 lanes). The reference model groups accepted elements into
// frames of frame_len, then cuts each frame into 4-element words.
module tb_mm_ln_out_pack;

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic [15:0] flen;
    } src_t;

    logic        clk;
    logic        rst;
    logic [15:0] frame_len;
    logic [7:0]  in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic        in_tlast;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        err_len;
    logic        state_dbg;
`ifdef PACK_STATS_EN
    logic [31:0] word_cnt;
    logic [15:0] frame_cnt;
`endif

    mm_ln_out_pack #(.D_W(8), .MATRIXSIZE_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_len     (frame_len),
        .in_tdata      (in_tdata),
        .in_tvalid     (in_tvalid),
        .in_tready     (in_tready),
        .in_tlast      (in_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .err_len       (err_len),
`ifdef PACK_STATS_EN
        .word_cnt      (word_cnt),
        .frame_cnt     (frame_cnt),
`endif
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    src_t        src_q[$];
    logic [36:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          vld_pct;
    int          rdy_pct;
    int          stall_left;
    bit          arm_stall;
    bit          hold_vld;
    logic [36:0] hold_word;
    bit          exp_err;
    int          n_words;
    int          n_frames;
    int          m_flen;
    int          m_cnt;
    int          m_lane;
    logic [31:0] m_word;
    logic [3:0]  m_keep;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame_len elements per frame, four per word, short last word.
    task automatic model_push(input src_t e);
        bit is_last;
        if (m_cnt == 0) m_flen = (e.flen == 16'd0) ? 1 : int'(e.flen);
        m_word = m_word | (32'(e.data) << (8 * m_lane));
        m_keep = m_keep | 4'(1 << m_lane);
        m_lane++;
        m_cnt++;
        is_last = (m_cnt == m_flen);
        if (e.last != is_last) exp_err = 1'b1;
        if (m_lane == 4 || is_last) begin
            exp_q.push_back({is_last, m_keep, m_word});
            m_word = '0;
            m_keep = '0;
            m_lane = 0;
        end
        if (is_last) m_cnt = 0;
    endtask

    // One clock cycle: drive both sides, then check outputs against the model.
    task automatic step();
        logic [36:0] got;
        @(negedge clk);
        if (src_q.size() > 0) frame_len = src_q[0].flen;
        if (src_q.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
            in_tvalid = 1'b1;
            in_tdata  = src_q[0].data;
            in_tlast  = src_q[0].last;
        end else begin
            in_tvalid = 1'b0;
            in_tdata  = 8'($urandom);
            in_tlast  = 1'($urandom);
        end
        if (stall_left > 0) begin
            m_axis_tready = 1'b0;
            stall_left--;
        end else begin
            m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
        end
        #1;
        got = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        check("tvalid", m_axis_tvalid, exp_q.size() != 0);
        check("in_tready", in_tready, !(exp_q.size() >= 2 && !m_axis_tready));
        if (hold_vld) check("hold", got, hold_word);
        hold_vld = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() > 0) check("word", got, exp_q.pop_front());
            n_words++;
            if (m_axis_tlast) n_frames++;
            if (arm_stall) begin
                stall_left = 5;
                arm_stall  = 1'b0;
            end
        end else if (m_axis_tvalid) begin
            hold_vld  = 1'b1;
            hold_word = got;
        end
        if (in_tvalid && in_tready) model_push(src_q.pop_front());
    endtask

    task automatic send_frame(input int flen, input int n, input logic [7:0] base, input int tlast_at);
        src_t e;
        for (int i = 0; i < n; i++) begin
            e.data = base + 8'(i);
            e.last = (i == tlast_at);
            e.flen = 16'(flen);
            src_q.push_back(e);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && guard < 400) begin
            step();
            guard++;
        end
        check("drain_timeout", guard < 400, 1);
        check("err_len", err_len, exp_err);
`ifdef PACK_STATS_EN
        check("word_cnt", word_cnt, n_words);
        check("frame_cnt", frame_cnt, n_frames);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        in_tvalid     = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        check("rst_in_tready", in_tready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_err_len", err_len, 0);
        check("rst_state", state_dbg, 0);
        check("rst_in_tready_after", in_tready, 1);
`ifdef PACK_STATS_EN
        check("rst_word_cnt", word_cnt, 0);
        check("rst_frame_cnt", frame_cnt, 0);
`endif
        src_q.delete();
        exp_q.delete();
        hold_vld   = 1'b0;
        stall_left = 0;
        arm_stall  = 1'b0;
        exp_err    = 1'b0;
        n_words    = 0;
        n_frames   = 0;
        m_cnt      = 0;
        m_lane     = 0;
        m_word     = '0;
        m_keep     = '0;
    endtask

    initial begin
        int base_words;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        frame_len = 16'd8;
        in_tdata = '0;
        in_tvalid = 1'b0;
        in_tlast = 1'b0;
        m_axis_tready = 1'b0;
        vld_pct = 100;
        rdy_pct = 100;
        do_reset();

        // 8 elements 0x01..0x08 -> 0x04030201, 0x08070605 (tlast)
        send_frame(8, 8, 8'h01, 7);
        drain();
        check("t1_words", n_words, 2);

        // frame_len=6 -> full word then a 2-lane word with tkeep=0x3
        send_frame(6, 6, 8'hA0, 5);
        drain();
        check("t2_words", n_words, 4);

        // 5-cycle stall after the first word, two frames back to back
        arm_stall = 1'b1;
        send_frame(8, 8, 8'h01, 7);
        send_frame(8, 8, 8'h21, 7);
        drain();

        // early in_tlast on element 4: err_len set, framing unchanged
        send_frame(8, 8, 8'h01, 3);
        drain();
        check("t4_err", err_len, 1);

        // reset mid-frame, then a clean 4-element frame
        send_frame(8, 3, 8'h55, -1);
        repeat (3) step();
        do_reset();
        send_frame(4, 4, 8'h11, 3);
        drain();
        check("t5_words", n_words, 1);

        // frame_len=0 behaves as 1
        send_frame(0, 1, 8'h7E, 0);
        drain();
        check("t6_frames", n_frames, 2);

        // three frames of 8: 6 words, 3 frames
        do_reset();
        repeat (3) send_frame(8, 8, 8'h40, 7);
        drain();
        check("t7_words", n_words, 6);
        check("t7_frames", n_frames, 3);

        // randomized frames, handshake rates and occasional tlast errors
        do_reset();
        for (int r = 0; r < 25; r++) begin
            vld_pct = $urandom_range(40, 100);
            rdy_pct = $urandom_range(25, 100);
            base_words = $urandom_range(1, 3);
            for (int f = 0; f < base_words; f++) begin
                int   flen;
                int   eff;
                int   tl;
                src_t e;
                flen = $urandom_range(0, 13);
                eff  = (flen == 0) ? 1 : flen;
                tl   = ($urandom_range(0, 99) < 15) ? $urandom_range(0, eff) : eff - 1;
                for (int i = 0; i < eff; i++) begin
                    e.data = 8'($urandom);
                    e.last = (i == tl);
                    e.flen = 16'(flen);
                    src_q.push_back(e);
                end
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
